// File: rtl/prewish_mask_blinker_pkg.sv
// Shared definitions for the prewish mask blinker: FSM encoding and widths.
package prewish_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MASK_W                = 8;
  localparam int IDX_W                 = 3;
  localparam int PRESCALE_BITS_DEFAULT = 21;

endpackage

// File: rtl/prewish_mask_blinker_prescaler.sv
// Free-running step counter for the blinker; tick marks the last clock of a bit slot.
module prewish_prescaler #(
  parameter int WIDTH = 21
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  logic [WIDTH-1:0] count;

  // Count up while enabled; clear has priority so IDLE and reset hold the count at zero.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tick = &count;

endmodule

// File: rtl/prewish_mask_blinker.sv
// Plays an 8-bit mask MSB-first on one LED, one bit per prescaler step,
// with mid-pattern writes buffered until the next pattern boundary.
module prewish_mask_blinker
  import prewish_pkg::*;
#(
  parameter int PRESCALE_BITS = PRESCALE_BITS_DEFAULT
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              o_led,
  output logic              o_alive
);

  state_t            state, state_next;
  logic [MASK_W-1:0] mask_reg, mask_next;
  logic [MASK_W-1:0] pend_reg, pend_next;
  logic              pend_valid, pend_valid_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic              ack_reg;
  logic              alive_reg;
  logic              tick;
  logic              boundary;

  prewish_prescaler #(
    .WIDTH (PRESCALE_BITS)
  ) u_prescaler (
    .clk    (CLK_I),
    .clear  (!RST_I || (state == IDLE)),
    .enable (state == RUN),
    .tick   (tick)
  );

  assign boundary = (state == RUN) && tick && (idx == '0);

  // Next-state, mask buffering and bit index; a write on the boundary beats any pending mask.
  always_comb begin
    state_next      = state;
    mask_next       = mask_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid;
    idx_next        = idx;
    case (state)
      IDLE: begin
        if (STB_I) begin
          mask_next  = DAT_I;
          idx_next   = IDX_W'(MASK_W - 1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (boundary) begin
          idx_next = IDX_W'(MASK_W - 1);
          if (STB_I) begin
            mask_next       = DAT_I;
            pend_valid_next = 1'b0;
          end else if (pend_valid) begin
            mask_next       = pend_reg;
            pend_valid_next = 1'b0;
          end
        end else begin
          if (tick) begin
            idx_next = idx - IDX_W'(1);
          end
          if (STB_I) begin
            pend_next       = DAT_I;
            pend_valid_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; every write is acked and toggles alive.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state      <= IDLE;
      mask_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      idx        <= IDX_W'(MASK_W - 1);
      ack_reg    <= 1'b0;
      alive_reg  <= 1'b0;
    end else begin
      state      <= state_next;
      mask_reg   <= mask_next;
      pend_reg   <= pend_next;
      pend_valid <= pend_valid_next;
      idx        <= idx_next;
      ack_reg    <= STB_I;
      alive_reg  <= alive_reg ^ STB_I;
    end
  end

  assign ACK_O   = ack_reg;
  assign o_alive = alive_reg;
  assign o_led   = (state == RUN) && mask_reg[idx];

endmodule
